// File: rtl/lc3_pkg.sv
// Shared LC-3 fetch/decode definitions: fetch FSM state encoding, reset PC,
// instruction payload type and the opcode constants used by the decoder.
package lc3_pkg;

  localparam int unsigned XLEN = 16;
  localparam int unsigned ST_W = 2;
  localparam int unsigned OP_W = 4;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_REQ   = 2'd1;
  localparam logic [ST_W-1:0] ST_HOLD  = 2'd2;
  localparam logic [ST_W-1:0] ST_DRAIN = 2'd3;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 16'h3000;

  localparam logic [OP_W-1:0] OP_BR  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND = 4'b0101;
  localparam logic [OP_W-1:0] OP_NOT = 4'b1001;

  // A fetched word together with the address it came from
  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] pc;
  } inst_t;

  function automatic logic [OP_W-1:0] opcode(input logic [XLEN-1:0] w);
    return w[XLEN-1 -: OP_W];
  endfunction

endpackage

// File: rtl/lc3_fetch_if.sv
// Fetch unit bus bundle: instruction-memory read channel, decoder handoff
// channel and the PC redirect strobe.
interface lc3_fetch_if;
  import lc3_pkg::*;

  logic [XLEN-1:0] mem_addr;
  logic            mem_rd;
  logic            mem_rdy;
  logic [XLEN-1:0] mem_data;
  logic [XLEN-1:0] instruction;
  logic            inst_valid;
  logic            inst_accept;
  logic [XLEN-1:0] inst_pc;
  logic            pc_load;
  logic [XLEN-1:0] pc_in;

  modport master (
    output mem_addr, mem_rd, instruction, inst_valid, inst_pc,
    input  mem_rdy, mem_data, inst_accept, pc_load, pc_in
  );

  modport slave (
    input  mem_addr, mem_rd, instruction, inst_valid, inst_pc,
    output mem_rdy, mem_data, inst_accept, pc_load, pc_in
  );

endinterface

// File: rtl/lc3_pc_reg.sv
// LC-3 program counter: redirect load has priority over the modulo-2^16 increment.
module lc3_pc_reg
  import lc3_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            inc,
  input  logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] pc_next_c
);

  logic [XLEN-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + XLEN'(1);
    end
  end

  assign pc_next_c = pc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/lc3_fetch.sv
// LC-3 instruction fetch FSM (IDLE/REQ/HOLD/DRAIN) with redirect handling.
// Define LC3_FETCH_PREFETCH_EN to add a one-entry prefetch buffer filled during HOLD.
module lc3_fetch
  import lc3_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  lc3_fetch_if.master bus
);

  logic [ST_W-1:0] state_q, state_d;
  logic            mem_rd_q, mem_rd_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  inst_t           inst_q, inst_d;
  logic            inst_valid_q, inst_valid_d;
  logic            pc_ld_c, pc_inc_c;
  logic [XLEN-1:0] pc_q, pc_next_c;
`ifdef LC3_FETCH_PREFETCH_EN
  inst_t           buf_q, buf_d;
  logic            buf_vld_q, buf_vld_d;
  logic            fill_c;
`endif

  lc3_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (pc_ld_c),
    .inc       (pc_inc_c),
    .load_val  (bus.pc_in),
    .pc_q      (pc_q),
    .pc_next_c (pc_next_c)
  );

  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    pc_ld_c      = 1'b0;
    pc_inc_c     = 1'b0;
`ifdef LC3_FETCH_PREFETCH_EN
    buf_d        = buf_q;
    buf_vld_d    = buf_vld_q;
    fill_c       = mem_rd_q && bus.mem_rdy;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (bus.pc_load) begin
          // Returned data (if any) belongs to the abandoned path
          pc_ld_c = 1'b1;
          state_d = bus.mem_rdy ? ST_REQ : ST_DRAIN;
        end else if (bus.mem_rdy) begin
          inst_d       = '{word: bus.mem_data, pc: pc_q};
          inst_valid_d = 1'b1;
          pc_inc_c     = 1'b1;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
`ifdef LC3_FETCH_PREFETCH_EN
        if (bus.pc_load) begin
          pc_ld_c      = 1'b1;
          inst_valid_d = 1'b0;
          buf_vld_d    = 1'b0;
          state_d      = (mem_rd_q && !bus.mem_rdy) ? ST_DRAIN : ST_REQ;
        end else if (bus.inst_accept) begin
          if (buf_vld_q) begin
            inst_d    = buf_q;
            buf_vld_d = 1'b0;
          end else if (fill_c) begin
            inst_d   = '{word: bus.mem_data, pc: pc_q};
            pc_inc_c = 1'b1;
          end else begin
            inst_valid_d = 1'b0;
            state_d      = ST_REQ;
          end
        end else if (fill_c) begin
          buf_d     = '{word: bus.mem_data, pc: pc_q};
          buf_vld_d = 1'b1;
          pc_inc_c  = 1'b1;
        end
`else
        if (bus.pc_load) begin
          pc_ld_c      = 1'b1;
          inst_valid_d = 1'b0;
          state_d      = ST_REQ;
        end else if (bus.inst_accept) begin
          inst_valid_d = 1'b0;
          state_d      = ST_REQ;
        end
`endif
      end
      ST_DRAIN: begin
        if (bus.pc_load) begin
          pc_ld_c = 1'b1;
        end
        if (bus.mem_rdy) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    mem_rd_d = (state_d == ST_REQ) || (state_d == ST_DRAIN);
`ifdef LC3_FETCH_PREFETCH_EN
    mem_rd_d = mem_rd_d || ((state_d == ST_HOLD) && !buf_vld_d);
`endif
    // The stale request keeps its address until memory answers it
    mem_addr_d = (state_d == ST_DRAIN) ? mem_addr_q : pc_next_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
`ifdef LC3_FETCH_PREFETCH_EN
      buf_q        <= '0;
      buf_vld_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
`ifdef LC3_FETCH_PREFETCH_EN
      buf_q        <= buf_d;
      buf_vld_q    <= buf_vld_d;
`endif
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.instruction = inst_q.word;
  assign bus.inst_pc     = inst_q.pc;
  assign bus.inst_valid  = inst_valid_q;

endmodule

// File: tb/tb_lc3_fetch.sv
// Bench for lc3_fetch (default build): directed vector table, then random
// memory latency / accept / redirect traffic checked against a PC-stream model.
module tb_lc3_fetch;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  lc3_fetch_if bus ();

  lc3_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [15:0] data;
    logic        acc;
    logic        ld;
    logic [15:0] pcin;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        chk_addr;
    logic        e_v;
    logic        chk_inst;
    logic [15:0] e_ins;
    logic [15:0] e_ipc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic rdy, input logic [15:0] data,
                              input logic acc, input logic ld, input logic [15:0] pcin,
                              input logic e_rd, input logic [15:0] e_addr, input logic chk_addr,
                              input logic e_v, input logic [15:0] e_ins, input logic [15:0] e_ipc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.data = data; v.acc = acc; v.ld = ld; v.pcin = pcin;
    v.e_rd = e_rd; v.e_addr = e_addr; v.chk_addr = chk_addr; v.e_v = e_v;
    v.chk_inst = e_v | rst; v.e_ins = e_ins; v.e_ipc = e_ipc;
    return v;
  endfunction

  // Instruction memory contents for the random phase
  function automatic logic [15:0] memfn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic drive(input logic rst, input logic rdy, input logic [15:0] data,
                       input logic acc, input logic ld, input logic [15:0] pcin);
    reset           = rst;
    bus.mem_rdy     = rdy;
    bus.mem_data    = data;
    bus.inst_accept = acc;
    bus.pc_load     = ld;
    bus.pc_in       = pcin;
  endtask

  initial begin
    logic        ok;
    logic [15:0] exp_pc;
    int          delivered;
    logic        p_rd, p_v, p_rdy, p_acc, p_ld;
    logic [15:0] p_addr, p_ins, p_ipc;
    logic        rd, v, acc, ld, rdy;
    logic [15:0] addr, ins, ipc, pcin, data;

    n_vec = 0;
    n_bad = 0;
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

    // rst rdy data acc ld pcin | rd addr chk_addr | v ins ipc
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h3000, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h3000, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h3000, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h3000, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h1261, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h1261, 16'h3000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h1261, 16'h3000));
    tbl.push_back(mk(0, 1, 16'hBEEF, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h1261, 16'h3000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h1261, 16'h3000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h1261, 16'h3000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h1261, 16'h3000));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h3001, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h5020, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h5020, 16'h3001));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h3002, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h4000, 1, 16'h3002, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h3002, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 16'hDEAD, 0, 0, 16'h0000, 1, 16'h4000, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h1111, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h1111, 16'h4000));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h5000, 1, 16'h5000, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h2222, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h2222, 16'h5000));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h5001, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h3333, 0, 1, 16'hFFFF, 1, 16'hFFFF, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h4444, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h4444, 16'hFFFF));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h6000, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h7000, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h9999, 0, 0, 16'h0000, 1, 16'h7000, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h7777, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h7777, 16'h7000));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h7001, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h3000, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h0BAD, 0, 0, 16'h0000, 1, 16'h3000, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h3000, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h0ABC, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0ABC, 16'h3000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h1234, 1, 16'h1234, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h5555, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h5555, 16'h1234));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].data, tbl[i].acc, tbl[i].ld, tbl[i].pcin);
      @(posedge clk);
      #1;
      ok = (bus.mem_rd === tbl[i].e_rd) && (bus.inst_valid === tbl[i].e_v) &&
           (!tbl[i].chk_addr || bus.mem_addr === tbl[i].e_addr) &&
           (!tbl[i].chk_inst || (bus.instruction === tbl[i].e_ins && bus.inst_pc === tbl[i].e_ipc));
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL vec%0d: got rd=%b addr=%h v=%b ins=%h ipc=%h, want rd=%b addr=%h v=%b ins=%h ipc=%h",
                 i, bus.mem_rd, bus.mem_addr, bus.inst_valid, bus.instruction, bus.inst_pc,
                 tbl[i].e_rd, tbl[i].e_addr, tbl[i].e_v, tbl[i].e_ins, tbl[i].e_ipc);
      end
    end

    // Random phase: fresh reset, then let the FSM leave IDLE before redirects
    @(negedge clk); drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk); drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk); drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    exp_pc    = 16'h3000;
    delivered = 0;
    p_rd  = bus.mem_rd;  p_v = bus.inst_valid; p_addr = bus.mem_addr;
    p_ins = bus.instruction; p_ipc = bus.inst_pc;
    p_rdy = 1'b0; p_acc = 1'b0; p_ld = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rd = bus.mem_rd; v = bus.inst_valid; addr = bus.mem_addr;
      ins = bus.instruction; ipc = bus.inst_pc;

      n_vec++;
      if (rd && v) begin
        n_bad++;
        $display("FAIL rd_while_valid cyc%0d: got mem_rd=%b inst_valid=%b, want not both", cyc, rd, v);
      end
      if (rd && p_rd && !p_rdy) begin
        n_vec++;
        if (addr !== p_addr) begin
          n_bad++;
          $display("FAIL addr_stable cyc%0d: got %h, want %h", cyc, addr, p_addr);
        end
      end
      if (v && p_v && !p_acc && !p_ld) begin
        n_vec++;
        if (ins !== p_ins || ipc !== p_ipc) begin
          n_bad++;
          $display("FAIL hold_stable cyc%0d: got %h@%h, want %h@%h", cyc, ins, ipc, p_ins, p_ipc);
        end
      end

      acc = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       pcin = 16'hFFFE;
        1:       pcin = 16'hFFFF;
        default: pcin = 16'($urandom);
      endcase
      if (rd) begin
        rdy  = 1'($urandom_range(0, 1));
        data = memfn(addr);
      end else begin
        rdy  = ($urandom_range(0, 7) == 0);
        data = 16'($urandom);
      end
      drive(1'b0, rdy, data, acc, ld, pcin);

      // Model: delivered words follow the PC stream; a redirect restarts it
      if (ld) begin
        exp_pc = pcin;
      end else if (v && acc) begin
        n_vec++;
        if (ins !== memfn(exp_pc) || ipc !== exp_pc) begin
          n_bad++;
          $display("FAIL deliver cyc%0d: got %h@%h, want %h@%h", cyc, ins, ipc, memfn(exp_pc), exp_pc);
        end
        exp_pc = exp_pc + 16'd1;
        delivered++;
      end

      p_rd = rd; p_v = v; p_addr = addr; p_ins = ins; p_ipc = ipc;
      p_rdy = rdy; p_acc = acc; p_ld = ld;
    end

    n_vec++;
    if (delivered < 100) begin
      n_bad++;
      $display("FAIL throughput: got %0d deliveries, want at least 100", delivered);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
